// File: rtl/ehgu_stride_checker.sv
// Stride checker: locks onto a fixed-increment stream, then flags and counts breaks.
// Optional EHGU_STRIDE_CHECKER_STICKY_FAIL_EN makes the first locked mismatch sticky.
module ehgu_stride_checker #(
  parameter int WIDTH         = 8,
  parameter int STRIDE        = 3,
  parameter int LOCK_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     locked,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]         exp_data,
`ifdef EHGU_STRIDE_CHECKER_STICKY_FAIL_EN
  output logic                     fail,
`endif
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    FAILED   = 2'd3
  } st_e;

  localparam logic [WIDTH-1:0] STEP   = WIDTH'(STRIDE);
  localparam logic [7:0]       LOCK_N = 8'(LOCK_COUNT);

  st_e                      st_q, st_d;
  logic [WIDTH-1:0]         prev_q, prev_d;
  logic [WIDTH-1:0]         exp_q, exp_d;
  logic [7:0]               run_q, run_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     lock_q;
`ifdef EHGU_STRIDE_CHECKER_STICKY_FAIL_EN
  logic                     fail_q;
`endif
  logic [WIDTH-1:0]         want;
  logic                     match;

  assign want  = prev_q + STEP;
  assign match = (data_in == want);

  always_comb begin
    st_d   = st_q;
    prev_d = prev_q;
    exp_d  = exp_q;
    run_d  = run_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (en) begin
      prev_d = data_in;
      exp_d  = data_in + STEP;
    end
    unique case (st_q)
      UNLOCKED: begin
        if (en) begin
          st_d  = ACQUIRE;
          run_d = 8'd1;
        end
      end
      ACQUIRE: begin
        if (en && match) begin
          run_d = run_q + 8'd1;
          if (run_q + 8'd1 == LOCK_N) st_d = LOCKED;
        end else if (en) begin
          run_d = 8'd1;
        end
      end
      LOCKED: begin
        if (en && !match) begin
          err_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
`ifdef EHGU_STRIDE_CHECKER_STICKY_FAIL_EN
          st_d  = FAILED;
`else
          st_d  = ACQUIRE;
          run_d = 8'd1;
`endif
        end
      end
      FAILED: begin
`ifndef EHGU_STRIDE_CHECKER_STICKY_FAIL_EN
        // unreachable without the sticky option; recover cleanly
        st_d  = UNLOCKED;
        run_d = 8'd0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= UNLOCKED;
      prev_q <= '0;
      exp_q  <= '0;
      run_q  <= 8'd0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      lock_q <= 1'b0;
`ifdef EHGU_STRIDE_CHECKER_STICKY_FAIL_EN
      fail_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      prev_q <= prev_d;
      exp_q  <= exp_d;
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      lock_q <= (st_d == LOCKED);
`ifdef EHGU_STRIDE_CHECKER_STICKY_FAIL_EN
      fail_q <= (st_d == FAILED);
`endif
    end
  end

  assign locked    = lock_q;
  assign err       = err_q;
  assign err_count = cnt_q;
  assign exp_data  = exp_q;
  assign state     = st_q;
`ifdef EHGU_STRIDE_CHECKER_STICKY_FAIL_EN
  assign fail      = fail_q;
`endif

endmodule

// File: doc/ehgu_stride_checker.md
Name: ehgu_stride_checker

Overview:
- Stream checker that sits directly downstream of ehgu_fifo and consumes its data_out.
- Verifies that successive qualified samples step by a fixed STRIDE (modulo 2^WIDTH).
- Acquires lock after LOCK_COUNT consecutive conforming samples, then flags and counts mismatches.
- Used in-bench and on-chip as a self-checking sink for incrementing-pattern traffic.

Parameters:
- WIDTH, 8, sample width in bits.
- STRIDE, 3, expected increment between consecutive qualified samples, taken modulo 2^WIDTH.
- LOCK_COUNT, 4, consecutive conforming samples needed to lock; legal range 2..255.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  sample qualifier; data_in is evaluated only when en=1.
- data_in  in  WIDTH  sample stream, normally driven from ehgu_fifo data_out.
- locked  out  1  1 while state=LOCKED.
- err  out  1  one-cycle pulse on a mismatch detected while LOCKED.
- err_count  out  ERR_CNT_WIDTH  number of mismatches detected while LOCKED; saturating.
- exp_data  out  WIDTH  value expected at the next qualified sample (prev + STRIDE).
- state  out  2  current FSM state encoding, for debug.

Behaviour:
- All outputs are registered.
- A sample taken at edge k updates the outputs, and they are visible after edge k.
- Reset (rst=1 at an edge), from any state including mid-stream:
  - state=UNLOCKED (0); prev=0; run_cnt=0.
  - locked=0, err=0, err_count=0, exp_data=0.
- en=0: state, prev, run_cnt and err_count hold; err=0; data_in is ignored.
- Match rule: data_in == (prev + STRIDE) truncated to WIDTH bits. Wrap is legal, e.g. 0xFF+3=0x02.
- On every qualified sample: prev<=data_in and exp_data<=data_in+STRIDE, in all states.
- UNLOCKED (0): first qualified sample sets run_cnt=1 and moves to ACQUIRE (1).
- ACQUIRE (1):
  - Match: run_cnt++. When the new run_cnt equals LOCK_COUNT, go to LOCKED (2) and set locked=1.
  - Mismatch: run_cnt=1 (the sample becomes the new run start); stay in ACQUIRE; no err, no count.
- LOCKED (2):
  - Match: stay.
  - Mismatch: err=1 for one cycle; err_count += 1, saturating at all-ones; locked=0; run_cnt=1; go to ACQUIRE.
- State 3 is FAIL, used only with the optional feature. Without the feature it is unreachable and falls back to UNLOCKED.
- run_cnt is 8 bits wide and never exceeds LOCK_COUNT.
- rst has priority over en and over every FSM transition.

Optional Feature:
- Macro: EHGU_STRIDE_CHECKER_STICKY_FAIL_EN.
- When defined:
  - A mismatch in LOCKED pulses err, increments err_count and enters FAIL (3).
  - FAIL holds until rst: locked=0, err stays 0, err_count frozen, prev/exp_data still track qualified samples.
  - Extra port fail (out, 1) = 1 in FAIL, reset to 0.
- When undefined: no fail port; the LOCKED mismatch path resyncs via ACQUIRE as described above.

Test Plan (WIDTH=8, STRIDE=3, LOCK_COUNT=4, ERR_CNT_WIDTH=16 unless noted):
1. rst for 2 cycles, then en=1, data 0x00,0x03,0x06,0x09 → locked=0 through 0x06; locked=1 after the edge sampling 0x09; err never 1; err_count=0; exp_data=0x0C.
2. Locked stream 0xF9,0xFC,0xFF,0x02,0x05 → locked stays 1; no err (wrap accepted); exp_data=0x08.
3. Locked after 0x1E, inject 0x50 instead of 0x21, then 0x53,0x56,0x59 → err=1 for exactly one cycle after 0x50; err_count=1; locked=0; locked=1 again after 0x59.
4. Locked at 0x30, en=0 for 5 cycles with data_in=0xAA, then en=1 with 0x33 → no err; locked stays 1; state unchanged during the gap.
5. ERR_CNT_WIDTH=4: relock then mismatch, repeated 20 times → err_count reaches 0xF and stays 0xF; err still pulses each time.
6. rst=1 for one edge while LOCKED with err_count=3 → after that edge: locked=0, err_count=0, state=0, exp_data=0x00. With STICKY_FAIL_EN defined, first mismatch → fail=1 and state=3, and they persist until rst.
